// File: rtl/rd_scoreboard_pkg.sv
// Shared constants and helpers for the register-destination scoreboard.
package rd_scoreboard_pkg;

  // Architectural register select width and the register count it spans.
  localparam int LA64_ARF_SEL = 5;
  localparam int ARF_N        = 2 ** LA64_ARF_SEL;

  // A tracked producer occupies EX1..WB plus the ARF write: five cycles.
  localparam logic [2:0] LIFE_INIT = 3'd5;

  // Tracking state held for one architectural register.
  typedef struct packed {
    logic       busy;
    logic [2:0] cnt;
    logic [2:0] life;
  } sb_state_t;

  // Cycles until a producer becomes bypassable. Out-of-range latencies
  // (0 or deeper than the bypass network) are treated as the deepest stage.
  function automatic logic [2:0] ready_cnt(input logic [2:0] lat,
                                           input logic [2:0] max_lat);
    logic [2:0] eff;
    eff = lat;
    if ((lat == 3'd0) || (lat > max_lat)) eff = max_lat;
    return eff - 3'd1;
  endfunction

endpackage

// File: rtl/rd_scoreboard_sb_entry.sv
// Busy / ready-countdown / life-countdown tracking for a single register.
module sb_entry
  import rd_scoreboard_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_flush,
  input  logic       i_set,
  input  logic [2:0] i_set_cnt,
  output logic       o_busy,
  output logic [2:0] o_cnt
);

  sb_state_t state_q;
  sb_state_t state_d;

  // Next state: flush wins, then a new producer, else count down the old one.
  always_comb begin
    state_d = state_q;
    if (i_flush) begin
      state_d = '0;
    end else if (i_set) begin
      state_d.busy = 1'b1;
      state_d.cnt  = i_set_cnt;
      state_d.life = LIFE_INIT;
    end else if (state_q.busy) begin
      state_d.cnt  = (state_q.cnt == 3'd0) ? 3'd0 : state_q.cnt - 3'd1;
      state_d.life = state_q.life - 3'd1;
      if (state_q.life == 3'd1) state_d = '0;
    end
  end

  // State register, cleared asynchronously by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= '0;
    else          state_q <= state_d;
  end

  assign o_busy = state_q.busy;
  assign o_cnt  = state_q.cnt;

endmodule

// File: rtl/rd_scoreboard.sv
// Dual-issue destination scoreboard: tracks in-flight producers per register
// and raises stall (hold the pair) or split (hold only i2) in ID.
module rd_scoreboard
  import rd_scoreboard_pkg::*;
#(
  parameter int NUM_ARF = ARF_N,
  parameter int MAX_LAT = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_i1_issue,
  input  logic                    i_i2_issue,
  input  logic                    i_i1_rd_we_id,
  input  logic                    i_i2_rd_we_id,
  input  logic [LA64_ARF_SEL-1:0] i_i1_rd_waddr_id,
  input  logic [LA64_ARF_SEL-1:0] i_i2_rd_waddr_id,
  input  logic [2:0]              i_i1_lat_id,
  input  logic [2:0]              i_i2_lat_id,
  input  logic [LA64_ARF_SEL-1:0] i_i1_rj_raddr_id,
  input  logic [LA64_ARF_SEL-1:0] i_i1_rk_raddr_id,
  input  logic [LA64_ARF_SEL-1:0] i_i2_rj_raddr_id,
  input  logic [LA64_ARF_SEL-1:0] i_i2_rk_raddr_id,
  input  logic                    i_i1_rj_re_id,
  input  logic                    i_i1_rk_re_id,
  input  logic                    i_i2_rj_re_id,
  input  logic                    i_i2_rk_re_id,
  output logic                    o_stall_id,
  output logic                    o_split_id,
  output logic [NUM_ARF-1:0]      o_busy_vec
);

  localparam logic [2:0] MAX_LAT_C = 3'(MAX_LAT);

  logic [ARF_N-1:0] busy_all;
  logic [2:0]       cnt_all [ARF_N];

  // Tracked writes; a flush cycle records nothing, r0 is never tracked.
  logic       i1_wr, i2_wr;
  logic [2:0] i1_cnt, i2_cnt;

  assign i1_wr  = i_i1_issue & i_i1_rd_we_id & (i_i1_rd_waddr_id != '0) & ~i_flush;
  assign i2_wr  = i_i2_issue & i_i2_rd_we_id & (i_i2_rd_waddr_id != '0) & ~i_flush;
  assign i1_cnt = ready_cnt(i_i1_lat_id, MAX_LAT_C);
  assign i2_cnt = ready_cnt(i_i2_lat_id, MAX_LAT_C);

  // One entry per tracked register; i2 is younger so its values win a tie.
  for (genvar r = 0; r < ARF_N; r++) begin : g_arf
    if ((r >= 1) && (r < NUM_ARF)) begin : g_ent
      logic hit1, hit2;
      assign hit1 = i1_wr & (i_i1_rd_waddr_id == LA64_ARF_SEL'(r));
      assign hit2 = i2_wr & (i_i2_rd_waddr_id == LA64_ARF_SEL'(r));
      sb_entry u_entry (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_flush   (i_flush),
        .i_set     (hit1 | hit2),
        .i_set_cnt (hit2 ? i2_cnt : i1_cnt),
        .o_busy    (busy_all[r]),
        .o_cnt     (cnt_all[r])
      );
    end else begin : g_zero
      assign busy_all[r] = 1'b0;
      assign cnt_all[r]  = 3'd0;
    end
  end

  // A source is hazarded while its producer is in flight and not yet bypassable.
  function automatic logic src_hz(input logic re, input logic [LA64_ARF_SEL-1:0] a);
    return re & (a != '0) & busy_all[a] & (cnt_all[a] != 3'd0);
  endfunction

  logic i1_hz, i2_hz, pair_dep;

  assign i1_hz    = src_hz(i_i1_rj_re_id, i_i1_rj_raddr_id) |
                    src_hz(i_i1_rk_re_id, i_i1_rk_raddr_id);
  assign i2_hz    = src_hz(i_i2_rj_re_id, i_i2_rj_raddr_id) |
                    src_hz(i_i2_rk_re_id, i_i2_rk_raddr_id);
  assign pair_dep = i_i1_rd_we_id & (i_i1_rd_waddr_id != '0) &
                    ((i_i2_rj_re_id & (i_i2_rj_raddr_id == i_i1_rd_waddr_id)) |
                     (i_i2_rk_re_id & (i_i2_rk_raddr_id == i_i1_rd_waddr_id)));

  // Outputs are forced quiet while reset is held.
  assign o_stall_id = i_rst_n & i1_hz;
  assign o_split_id = i_rst_n & ~i1_hz & (i2_hz | pair_dep);
  assign o_busy_vec = i_rst_n ? busy_all[NUM_ARF-1:0] : '0;

endmodule

// File: doc/rd_scoreboard.md
RD_SCOREBOARD -- requirements
Module: rd_scoreboard

Interface
REQ-001 Parameter NUM_ARF, default 2**`LA64_ARF_SEL (32), number of architectural integer registers tracked.
REQ-002 Parameter MAX_LAT, default 4, deepest producer stage (1=EX1 .. 4=EX4) whose result reaches the bypass network.
REQ-003 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  asynchronous, active-low reset.
REQ-005 i_flush  input  1  pipeline flush; discards all in-flight producers.
REQ-006 i_i1_issue / i_i2_issue  input  1 each  slot i1/i2 leaves ID into EX1 this cycle.
REQ-007 i_i1_rd_we_id / i_i2_rd_we_id  input  1 each  issuing instruction writes rd.
REQ-008 i_i1_rd_waddr_id / i_i2_rd_waddr_id  input  `LA64_ARF_SEL each  destination register.
REQ-009 i_i1_lat_id / i_i2_lat_id  input  3 each  stage (1..MAX_LAT) where the result becomes final and bypassable.
REQ-010 i_i1_rj_raddr_id, i_i1_rk_raddr_id, i_i2_rj_raddr_id, i_i2_rk_raddr_id  input  `LA64_ARF_SEL each  ID source registers.
REQ-011 i_i1_rj_re_id, i_i1_rk_re_id, i_i2_rj_re_id, i_i2_rk_re_id  input  1 each  source actually read.
REQ-012 o_stall_id  output  1  i1 (and the pair) must hold in ID.
REQ-013 o_split_id  output  1  i1 may issue, i2 must hold (intra-pair or i2-only hazard).
REQ-014 o_busy_vec  output  NUM_ARF  per-register in-flight indication (debug/verification).

Function
REQ-015 Per register: busy bit, ready countdown cnt (3 bits), life countdown life (3 bits).
REQ-016 On issue with rd_we=1 and waddr!=0: busy<=1, cnt<=lat-1, life<=5 (EX1..WB plus ARF write).
REQ-017 Writes to r0 are never tracked; busy_vec[0] SHALL be 0.
REQ-018 Every other cycle: busy entries decrement cnt saturating at 0; decrement life; life reaching 0 clears busy.
REQ-019 If i1 and i2 issue to the same rd in one cycle, i2 (younger) values win.
REQ-020 A new issue to an already busy register overwrites cnt/life (newest producer governs).
REQ-021 Source hazard = re & raddr!=0 & busy[raddr] & cnt[raddr]!=0, evaluated on registered state (combinational read, no added latency).
REQ-022 o_stall_id = any i1 source hazard.
REQ-023 o_split_id = ~o_stall_id & (any i2 source hazard | i2 reads rd of i1 with i1 rd_we and rd!=0).
REQ-024 Zero-latency bypass: producer with lat=1 issued at cycle t SHALL not stall a consumer in ID at t+1.
REQ-025 General rule: consumer in ID at t+k is stalled iff k < lat.
REQ-026 i_flush=1: all entries cleared at the next edge; issues in the flush cycle are ignored; outputs in that cycle still reflect pre-flush state.
REQ-027 lat values 0 or >MAX_LAT are treated as MAX_LAT.

Reset
REQ-028 i_rst_n low clears all busy, cnt, life asynchronously; o_stall_id=0, o_split_id=0, o_busy_vec=0 while in reset.
REQ-029 Deassertion mid-issue: the first edge after release SHALL be the first recorded issue.

Structure
REQ-030 `LA64_ARF_SEL, `LA64_DATA_WIDTH, MAX_LAT stage encodings stay in constants.vh.
REQ-031 One sub-module, sb_entry (busy/cnt/life for one register), instantiated NUM_ARF-1 times; hazard compare and priority logic in the top.

Verification
REQ-032 Issue i1 rd=5 lat=1 at t; i1 reads r5 at t+1 -> o_stall_id=0; busy_vec[5] clears after 5 edges.
REQ-033 Issue i1 rd=7 lat=4 at t; i1 reads r7 -> o_stall_id=1 at t+1..t+3, 0 at t+4.
REQ-034 Same pair: i1 writes r3, i2 reads r3 -> o_split_id=1, o_stall_id=0; with i1 rd=0 -> o_split_id=0.
REQ-035 i1 rd=9 lat=1, i2 rd=9 lat=3 same cycle; read r9 at t+1 -> stall until t+3.
REQ-036 Issue rd=12 lat=4, i_flush at t+1 -> busy_vec=0 at t+2, no stall on r12.
REQ-037 Assert i_rst_n=0 asynchronously with three busy entries -> busy_vec=0 immediately, outputs 0.
